// File: rtl/mem_req_ctrl.sv
// Y86 SEQ memory-stage initiator: decodes icode into at most one load or store,
// issues it to a word-addressed responder and reports val_m, done, bad_mem and timeout.
module mem_req_ctrl #(
    parameter int MEM_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  in_code,
    input  logic [63:0] val_e,
    input  logic [63:0] val_a,
    input  logic [63:0] val_p,
    output logic        busy,
    output logic        done,
    output logic [63:0] val_m,
    output logic        bad_mem,
    output logic        timeout,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata
);

    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [63:0]     ADDR_LIMIT = 64'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic             dec_access;
    logic             dec_write;
    logic [63:0]      dec_addr;
    logic [63:0]      dec_wdata;
    logic             dec_in_range;
    logic             start_accept;
    logic             in_flight;
    logic             expire;
    logic             exit_ok;
    logic             abort;
    logic [CNT_W-1:0] cnt;

    // Operand selection for the icode currently presented with start.
    always_comb begin
        dec_access = 1'b0;
        dec_write  = 1'b0;
        dec_addr   = val_e;
        dec_wdata  = '0;
        case (in_code)
            ICODE_MRMOVQ: begin
                dec_access = 1'b1;
            end
            ICODE_RET, ICODE_POPQ: begin
                dec_access = 1'b1;
                dec_addr   = val_a;
            end
            ICODE_RMMOVQ, ICODE_PUSHQ: begin
                dec_access = 1'b1;
                dec_write  = 1'b1;
                dec_wdata  = val_a;
            end
            ICODE_CALL: begin
                dec_access = 1'b1;
                dec_write  = 1'b1;
                dec_wdata  = val_p;
            end
            default: begin
                dec_access = 1'b0;
            end
        endcase
    end

    assign dec_in_range = (dec_addr < ADDR_LIMIT);
    assign start_accept = (state == IDLE) && start;
    assign in_flight    = (state == REQ) || (state == WAIT);
    assign expire       = in_flight && (cnt == CNT_LAST);

    // Request channel: mem_req_valid is high exactly while in REQ, and write/addr/wdata
    // stay constant while it is high; the request transfers on a rising edge that sees
    // valid && ready. The response channel has no back-pressure: mem_rsp_valid is a
    // one-cycle pulse that is honoured only in WAIT and ignored in every other state.
    assign exit_ok = ((state == REQ) && mem_req_ready) ||
                     ((state == WAIT) && mem_rsp_valid);
    assign abort   = expire && !exit_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (dec_access && dec_in_range) ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                end else if (expire) begin
                    state_next = DONE;
                end
            end
            WAIT: begin
                if (mem_rsp_valid || expire) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign mem_req_valid = (state == REQ);

    // Cycle budget shared by REQ and WAIT; restarted whenever a start is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start_accept) begin
            cnt <= '0;
        end else if (in_flight) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            bad_mem       <= 1'b0;
            timeout       <= 1'b0;
            val_m         <= '0;
        end else begin
            if (start_accept) begin
                bad_mem <= dec_access && !dec_in_range;
                timeout <= 1'b0;
                if (dec_access && dec_in_range) begin
                    mem_req_write <= dec_write;
                    mem_req_addr  <= dec_addr;
                    mem_req_wdata <= dec_wdata;
                end
            end
            // A store's response is only an acknowledgement.
            if ((state == WAIT) && mem_rsp_valid && !mem_req_write) begin
                val_m <= mem_rsp_rdata;
            end
            if (abort) begin
                bad_mem <= 1'b1;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Memory-stage initiator for the Y86 SEQ datapath. Issues one load or store per instruction to a word-addressed data-memory responder over a valid/ready request channel and a response channel.
- Decodes icode into read/write/none, selects address and write data, and bounds-checks the address.
- Returns val_m plus done/bad_mem/timeout status to the writeback and PC-update stages.

Parameters:
MEM_WORDS, 1024, number of 64-bit words in the responder; legal addresses are 0..MEM_WORDS-1
TIMEOUT_CYCLES, 16, maximum cycles spent in REQ plus WAIT before abort; must be >= 2

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: operand fields valid, begin memory access
in_code  input  4  instruction icode
val_e  input  64  ALU result
val_a  input  64  register A value
val_p  input  64  incremented PC
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
val_m  output  64  loaded word, registered
bad_mem  output  1  registered; address out of range or timeout, valid with done
timeout  output  1  registered; responder did not answer in time, valid with done
mem_req_valid  output  1  request valid
mem_req_ready  input  1  responder accepts request
mem_req_write  output  1  1 = store, 0 = load
mem_req_addr  output  64  word address
mem_req_wdata  output  64  store data
mem_rsp_valid  input  1  response/ack from responder, one-cycle pulse
mem_rsp_rdata  input  64  load data, valid with mem_rsp_valid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are clock and reset.
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset mid-transaction drops mem_req_valid immediately, with no done pulse.
- Decode, captured at start:
  - Read, address val_e: icode 5 (mrmovq).
  - Read, address val_a: icode 9 (ret), 11 (popq).
  - Write, address val_e, data val_a: icode 4 (rmmovq), 10 (pushq).
  - Write, address val_e, data val_p: icode 8 (call).
  - All other icodes: no access.
- States are IDLE, REQ, WAIT, DONE.
- IDLE:
  - start with a memory icode and addr < MEM_WORDS: go to REQ. Latch addr, wdata and write. Clear bad_mem and timeout.
  - start with addr >= MEM_WORDS (unsigned 64-bit compare): go to DONE with bad_mem=1. No request is issued.
  - start with a non-memory icode: go to DONE, bad_mem=0, val_m unchanged.
  - start while busy is ignored.
- REQ:
  - mem_req_valid=1. Addr, wdata and write are held stable until mem_req_ready.
  - A cycle with valid && ready is the handshake. Next state is WAIT and valid drops.
- WAIT:
  - mem_rsp_valid=1 takes the FSM to DONE.
  - Loads register val_m from mem_rsp_rdata on that edge. Stores treat the response as an ack and leave val_m unchanged.
  - rsp_valid is sampled only in WAIT. A response in the same cycle as the request handshake is not allowed; the responder answers at least 1 cycle later.
- Timeout:
  - The counter is cleared on entry to REQ and increments each cycle in REQ or WAIT.
  - When count == TIMEOUT_CYCLES-1 and the exit condition is not met, go to DONE with timeout=1 and bad_mem=1. mem_req_valid drops and val_m is unchanged.
  - If the handshake or response occurs in that same cycle, normal completion wins.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - bad_mem, timeout and val_m hold their values until the next start is accepted.
- Minimum latencies, counted from the start cycle T:
  - No-access or bad address: done at T+1.
  - Zero-wait responder (ready=1, rsp at the first WAIT cycle): done at T+3.
- Stray mem_rsp_valid in IDLE, REQ or DONE is ignored.
- Address is a word index; no byte alignment check.

Test Plan:
- mrmovq: in_code=5, val_e=3. Responder ready=1, rsp 1 cycle later with rdata=8 -> req addr=3, write=0; done at T+3, val_m=8, bad_mem=0.
- pushq then popq: in_code=10, val_e=20, val_a=0xABCD -> req write=1, addr=20, wdata=0xABCD. Then in_code=11, val_a=20 -> read addr=20, val_m=0xABCD.
- call: in_code=8, val_e=7, val_p=0x40 -> wdata=0x40. Hold ready=0 for 3 cycles -> addr and wdata stable, valid held; done after ack.
- Bad address: in_code=5, val_e=1024 -> no mem_req_valid; done at T+1, bad_mem=1.
- Non-memory op: in_code=6 with val_m previously 8 -> done at T+1, val_m=8, bad_mem=0.
- Timeout and reset: ready=1, responder never answers -> done with timeout=1, bad_mem=1 exactly 16 cycles after REQ entry. Separately, reset asserted in REQ -> valid=0 immediately, no done.
